maze_agent_tracker: RTL and testbench
=====================================

MAZE_AGENT_TRACKER -- requirements
Module: maze_agent_tracker

Interface
REQ-001 Parameter DATA_W, 8, pixel width.
REQ-002 Parameter LINE_MAX, 1024, maximum pixels per line; also the line-buffer depth.
REQ-003 Parameter WIN, 33, window side in pixels; odd, 3..63; HALF = (WIN-1)/2.
REQ-004 Parameter STEP, 8, agent move per frame in pixels; must be below HALF.
REQ-005 Parameter MARK_HALF, 4, half-side of the drawn marker square.
REQ-006 Parameter CW, 10, coordinate width.
REQ-007 Port: clk  in  1  sole clock, all logic on rising edge.
REQ-008 Port: reset  in  1  synchronous, active-low.
REQ-009 Port: mode  in  2  output select: 0 raw, 1 binary, 2 binary+marker, 3 raw+marker.
REQ-010 Port: video_frame_valid / video_line_valid / video_data_valid  in  1 each  stream framing and pixel strobe.
REQ-011 Port: video_data_in  in  DATA_W  grey pixel.
REQ-012 Port: threshold  in  DATA_W  binarisation level, sampled each pixel.
REQ-013 Port: agent_load  in  1  pulse; loads start_x/start_y.
REQ-014 Port: start_x, start_y  in  CW each  start column/row.
REQ-015 Port: video_data_ready  out  1  registered copy of video_data_valid, aligned with video_data_out.
REQ-016 Port: video_data_out  out  DATA_W  processed pixel.
REQ-017 Port: agent_x, agent_y  out  CW each; agent_dir  out  2 (N=0,E=1,S=2,W=3); agent_stuck  out  1.

Function
REQ-018 cnt_h increments on video_data_valid, clears on falling edge of video_line_valid; cnt_v increments on that edge and clears on falling edge of video_frame_valid; both saturate at LINE_MAX-1.
REQ-019 Binary pixel b = 1 when video_data_in > threshold (strict), else 0.
REQ-020 WIN-1 lines of binary pixels are buffered; window row r, column c holds pixel (cnt_h-c, cnt_v-r); rows not yet written in the current frame and columns with cnt_h-c < 0 read as 0.
REQ-021 Window centre pixel is at (cnt_h-HALF, cnt_v-HALF).
REQ-022 When the centre equals (agent_x, agent_y) on a valid pixel, four probes latch: N = row 2*HALF col HALF; S = row 0 col HALF; W = row HALF col 2*HALF; E = row HALF col 0; probe_hit sets.
REQ-023 FSM states IDLE, ARMED, DECIDE, STUCK; reset enters IDLE.
REQ-024 agent_load in any state: agent_x/y <= start_x/start_y, dir <= S, probes/probe_hit cleared, state <= ARMED; when coincident with frame end, load wins.
REQ-025 ARMED: on falling edge of video_frame_valid -> DECIDE.
REQ-026 DECIDE (one cycle): if !probe_hit, no move; else first open probe in order right-of-dir, dir, left-of-dir, reverse; dir <= that, position += STEP along it; all four closed -> STUCK; otherwise -> ARMED; probe_hit cleared.
REQ-027 Moved coordinates clamp to [HALF, LINE_MAX-1-HALF]; arithmetic is CW-bit unsigned with no wrap.
REQ-028 STUCK: agent_stuck = 1, position frozen, left only by agent_load or reset.
REQ-029 Output latency is 1 cycle from video_data_valid; mode 0 passes the pixel, mode 1 gives all-ones/zero from b.
REQ-030 Modes 2/3 replace the pixel with {1'b1, zeros} when |cnt_h-agent_x| <= MARK_HALF and |cnt_v-agent_y| <= MARK_HALF; the marker is not drawn in IDLE.
REQ-031 Position changes only in DECIDE, so a frame is never drawn with a split marker.

Reset
REQ-032 While reset = 0 at a clock edge: video_data_out = 0, video_data_ready = 0, counters = 0, agent_x = agent_y = 0, agent_dir = S, agent_stuck = 0, state = IDLE, probes = 0.
REQ-033 Reset mid-frame discards the partial frame; window masking restarts at the next frame.
REQ-034 Line-buffer RAM contents need no reset; masking per REQ-020 covers them.

Structure
REQ-035 Package maze_pkg holds the direction encoding, FSM state encoding, mode constants, and the right/left/reverse direction functions.
REQ-036 One sub-module, bin_line_buffer, implements WIN-1 lines x LINE_MAX x 1-bit storage with one write and one read per pixel; the window shift register stays in the top level.

Verification
REQ-037 Frame of 64x64, threshold 150, pixels 151 -> out 8'hFF in mode 1; pixels 150 -> 8'h00; ready trails valid by 1 cycle.
REQ-038 Vertical corridor at x=30..40, load (35,20), 3 frames -> agent_y = 28, 36, 44, dir S, stuck 0.
REQ-039 Corridor turning east at y=60, agent heading S at (35,60) -> next frame dir E, agent_x = 43.
REQ-040 Agent in a closed 9x9 box -> one frame later agent_stuck = 1, position unchanged; agent_load clears it.
REQ-041 Mode 2 with agent at (100,100) -> pixels 96..104 on rows 96..104 read 8'h80, pixel 105 reads binary.
REQ-042 agent_load on the same cycle as frame end -> start position loaded, no move; reset asserted mid-line -> all outputs 0 next cycle.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared encodings for the maze agent tracker: headings, FSM states, output modes.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package maze_pkg;

  // Agent heading, clockwise from north so "right" is +1 and "left" is -1.
  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    DECIDE = 2'd2,
    STUCK  = 2'd3
  } state_t;

  // Output select values for the mode port.
  localparam logic [1:0] MODE_RAW      = 2'd0;
  localparam logic [1:0] MODE_BIN      = 2'd1;
  localparam logic [1:0] MODE_BIN_MARK = 2'd2;
  localparam logic [1:0] MODE_RAW_MARK = 2'd3;

  function automatic dir_t dir_right(input dir_t d);
    dir_t r;
    case (d)
      DIR_N:   r = DIR_E;
      DIR_E:   r = DIR_S;
      DIR_S:   r = DIR_W;
      default: r = DIR_N;
    endcase
    return r;
  endfunction

  function automatic dir_t dir_left(input dir_t d);
    dir_t r;
    case (d)
      DIR_N:   r = DIR_W;
      DIR_E:   r = DIR_N;
      DIR_S:   r = DIR_E;
      default: r = DIR_S;
    endcase
    return r;
  endfunction

  function automatic dir_t dir_reverse(input dir_t d);
    dir_t r;
    case (d)
      DIR_N:   r = DIR_S;
      DIR_E:   r = DIR_W;
      DIR_S:   r = DIR_N;
      default: r = DIR_E;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bin_line_buffer.sv
// Column-organised store of the last LINES binary lines: one word per pixel column.
// Latency: read is combinational from addr; write lands on the rising edge.
// Backpressure: none; one read and one write per accepted pixel.
// Ports: clk; wr_en write strobe; addr pixel column; wr_dat new column word;
//        rd_dat current column word (bit k = line k+1 above the current one).
module bin_line_buffer #(
  parameter int DEPTH = 1024,
  parameter int LINES = 32,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [LINES-1:0] wr_dat,
  output logic [LINES-1:0] rd_dat
);

  logic [LINES-1:0] mem [DEPTH];

  assign rd_dat = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_dat;
    end
  end

endmodule

// File: rtl/maze_agent_tracker.sv
// Binarises a video stream, probes a WIN x WIN window around a maze agent and steps it once per frame.
// Latency: 1 cycle from video_data_valid to video_data_ready/video_data_out.
// Backpressure: none; every valid pixel is accepted and produces exactly one output pixel.
// Ports: clk, reset (sync active-low); mode output select; video_* framing/pixel in; threshold;
//        agent_load/start_x/start_y reposition; video_data_ready/out processed pixel; agent_* status.
module maze_agent_tracker
  import maze_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LINE_MAX  = 1024,
  parameter int WIN       = 33,
  parameter int STEP      = 8,
  parameter int MARK_HALF = 4,
  parameter int CW        = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              video_frame_valid,
  input  logic              video_line_valid,
  input  logic              video_data_valid,
  input  logic [DATA_W-1:0] video_data_in,
  input  logic [DATA_W-1:0] threshold,
  input  logic              agent_load,
  input  logic [CW-1:0]     start_x,
  input  logic [CW-1:0]     start_y,
  output logic              video_data_ready,
  output logic [DATA_W-1:0] video_data_out,
  output logic [CW-1:0]     agent_x,
  output logic [CW-1:0]     agent_y,
  output logic [1:0]        agent_dir,
  output logic              agent_stuck
);

  localparam int HALF = (WIN - 1) / 2;
  localparam int LB_W = WIN - 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(LINE_MAX - 1);
  localparam logic signed [CW+1:0] POS_LO = (CW+2)'(HALF);
  localparam logic signed [CW+1:0] POS_HI = (CW+2)'(LINE_MAX - 1 - HALF);
  localparam logic signed [CW+1:0] STEP_S = (CW+2)'(STEP);
  localparam logic [DATA_W-1:0] MARK_PIX = {1'b1, {(DATA_W-1){1'b0}}};

  logic line_d, frame_d, line_fall, frame_fall;
  logic [CW-1:0] cnt_h, cnt_v;
  logic pix_b;
  logic [LB_W-1:0] lb_rd, lb_wr;
  logic row_mid_in, row_top_in;
  // Column history for the three window rows the probes look at; bit k = column k+1.
  logic [HALF-1:0]   sr_top, sr_bot;
  logic [2*HALF-1:0] sr_mid;
  logic [3:0] probe;  // indexed by dir_t, 1 = open
  logic probe_hit, hit_now;
  state_t state, state_nxt;
  dir_t dir, cand_r, cand_l, cand_b, new_dir;
  logic marker_en, is_decide, is_armed;
  logic [CW-1:0] next_x, next_y;
  logic signed [CW+1:0] ext_x, ext_y;
  logic [CW-1:0] dx, dy;
  logic [DATA_W-1:0] base_pix, pix_nxt;
  logic mark_mode;

  assign line_fall  = line_d & ~video_line_valid;
  assign frame_fall = frame_d & ~video_frame_valid;
  assign pix_b      = (video_data_in > threshold);

  // Raster counters; a falling framing edge clears before any increment applies.
  always_ff @(posedge clk) begin
    if (!reset) begin
      line_d  <= 1'b0;
      frame_d <= 1'b0;
      cnt_h   <= '0;
      cnt_v   <= '0;
    end else begin
      line_d  <= video_line_valid;
      frame_d <= video_frame_valid;
      if (line_fall) cnt_h <= '0;
      else if (video_data_valid && cnt_h != CNT_MAX) cnt_h <= cnt_h + CW'(1);
      if (frame_fall) cnt_v <= '0;
      else if (line_fall && cnt_v != CNT_MAX) cnt_v <= cnt_v + CW'(1);
    end
  end

  // Each column word shifts one line older as the current pixel is pushed in at bit 0.
  assign lb_wr = {lb_rd[LB_W-2:0], pix_b};

  bin_line_buffer #(
    .DEPTH (LINE_MAX),
    .LINES (LB_W),
    .AW    (CW)
  ) u_line_buf (
    .clk    (clk),
    .wr_en  (video_data_valid),
    .addr   (cnt_h),
    .wr_dat (lb_wr),
    .rd_dat (lb_rd)
  );

  // Lines from before the start of this frame hold stale data and are forced closed.
  assign row_mid_in = (cnt_v >= CW'(HALF))     ? lb_rd[HALF-1] : 1'b0;
  assign row_top_in = (cnt_v >= CW'(2 * HALF)) ? lb_rd[LB_W-1] : 1'b0;

  // Clearing at line end makes columns left of the line start read as closed.
  always_ff @(posedge clk) begin
    if (!reset || line_fall) begin
      sr_top <= '0;
      sr_mid <= '0;
      sr_bot <= '0;
    end else if (video_data_valid) begin
      sr_top <= (sr_top << 1) | HALF'(row_top_in);
      sr_mid <= (sr_mid << 1) | (2*HALF)'(row_mid_in);
      sr_bot <= (sr_bot << 1) | HALF'(pix_b);
    end
  end

  // Window centre trails the raster by HALF in both axes.
  assign hit_now = is_armed && video_data_valid &&
                   ({1'b0, cnt_h} == {1'b0, agent_x} + (CW+1)'(HALF)) &&
                   ({1'b0, cnt_v} == {1'b0, agent_y} + (CW+1)'(HALF));

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state; a load overrides everything, including a coincident frame end.
  always_comb begin
    state_nxt = state;
    if (agent_load) begin
      state_nxt = ARMED;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        ARMED:   if (frame_fall) state_nxt = DECIDE;
        DECIDE:  state_nxt = (probe_hit && !(|probe)) ? STUCK : ARMED;
        STUCK:   state_nxt = STUCK;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM: outputs.
  always_comb begin
    agent_stuck = 1'b0;
    marker_en   = 1'b1;
    is_decide   = 1'b0;
    is_armed    = 1'b0;
    case (state)
      IDLE:    marker_en   = 1'b0;
      ARMED:   is_armed    = 1'b1;
      DECIDE:  is_decide   = 1'b1;
      default: agent_stuck = 1'b1;
    endcase
  end

  // Wall-follower preference: right, straight, left, back.
  always_comb begin
    cand_r  = dir_right(dir);
    cand_l  = dir_left(dir);
    cand_b  = dir_reverse(dir);
    new_dir = dir;
    if (probe[cand_r])      new_dir = cand_r;
    else if (probe[dir])    new_dir = dir;
    else if (probe[cand_l]) new_dir = cand_l;
    else if (probe[cand_b]) new_dir = cand_b;
  end

  function automatic logic [CW-1:0] clamp_pos(input logic signed [CW+1:0] v);
    logic signed [CW+1:0] c;
    if (v < POS_LO)      c = POS_LO;
    else if (v > POS_HI) c = POS_HI;
    else                 c = v;
    return CW'(c);
  endfunction

  assign ext_x = signed'({2'b00, agent_x});
  assign ext_y = signed'({2'b00, agent_y});

  always_comb begin
    next_x = agent_x;
    next_y = agent_y;
    case (new_dir)
      DIR_N:   next_y = clamp_pos(ext_y - STEP_S);
      DIR_E:   next_x = clamp_pos(ext_x + STEP_S);
      DIR_S:   next_y = clamp_pos(ext_y + STEP_S);
      default: next_x = clamp_pos(ext_x - STEP_S);
    endcase
  end

  // Agent position only changes in DECIDE, between frames, so a marker is never split.
  always_ff @(posedge clk) begin
    if (!reset) begin
      agent_x   <= '0;
      agent_y   <= '0;
      dir       <= DIR_S;
      probe     <= '0;
      probe_hit <= 1'b0;
    end else if (agent_load) begin
      agent_x   <= start_x;
      agent_y   <= start_y;
      dir       <= DIR_S;
      probe     <= '0;
      probe_hit <= 1'b0;
    end else if (is_decide) begin
      if (probe_hit && (|probe)) begin
        dir     <= new_dir;
        agent_x <= next_x;
        agent_y <= next_y;
      end
      probe     <= '0;
      probe_hit <= 1'b0;
    end else if (hit_now) begin
      probe     <= {sr_mid[2*HALF-1], sr_bot[HALF-1], row_mid_in, sr_top[HALF-1]};
      probe_hit <= 1'b1;
    end
  end

  assign agent_dir = dir;

  assign dx = (cnt_h >= agent_x) ? cnt_h - agent_x : agent_x - cnt_h;
  assign dy = (cnt_v >= agent_y) ? cnt_v - agent_y : agent_y - cnt_v;

  always_comb begin
    base_pix  = video_data_in;
    mark_mode = 1'b0;
    case (mode)
      MODE_RAW:      base_pix = video_data_in;
      MODE_BIN:      base_pix = {DATA_W{pix_b}};
      MODE_BIN_MARK: begin base_pix = {DATA_W{pix_b}}; mark_mode = 1'b1; end
      MODE_RAW_MARK: begin base_pix = video_data_in;   mark_mode = 1'b1; end
      default:       base_pix = video_data_in;
    endcase
    pix_nxt = base_pix;
    if (mark_mode && marker_en && dx <= CW'(MARK_HALF) && dy <= CW'(MARK_HALF)) begin
      pix_nxt = MARK_PIX;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      video_data_ready <= 1'b0;
      video_data_out   <= '0;
    end else begin
      video_data_ready <= video_data_valid;
      if (video_data_valid) video_data_out <= pix_nxt;
    end
  end

endmodule

// File: tb/tb_maze_agent_tracker.sv
// Scoreboard bench for maze_agent_tracker: frames are built as images, every issued pixel
// pushes its expected output, a negedge monitor pops on video_data_ready, and a frame-level
// agent model (image lookups, turn order, clamping) predicts the agent after every frame.
module tb_maze_agent_tracker;

  localparam int DATA_W = 8, LINE_MAX = 1024, WIN = 33, HALF = 16;
  localparam int STEP = 8, MARK_HALF = 4, CW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, video_frame_valid, video_line_valid, video_data_valid, agent_load;
  logic [1:0] mode;
  logic [DATA_W-1:0] video_data_in, threshold;
  logic [CW-1:0] start_x, start_y;
  logic video_data_ready, agent_stuck;
  logic [DATA_W-1:0] video_data_out;
  logic [CW-1:0] agent_x, agent_y;
  logic [1:0] agent_dir;

  maze_agent_tracker #(
    .DATA_W(DATA_W), .LINE_MAX(LINE_MAX), .WIN(WIN), .STEP(STEP),
    .MARK_HALF(MARK_HALF), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .video_frame_valid(video_frame_valid), .video_line_valid(video_line_valid),
    .video_data_valid(video_data_valid), .video_data_in(video_data_in),
    .threshold(threshold), .agent_load(agent_load), .start_x(start_x), .start_y(start_y),
    .video_data_ready(video_data_ready), .video_data_out(video_data_out),
    .agent_x(agent_x), .agent_y(agent_y), .agent_dir(agent_dir), .agent_stuck(agent_stuck)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  logic [7:0] img  [128][128];
  bit         bimg [128][128];

  // Reference agent: idle flag, stuck flag, position, heading (0=N,1=E,2=S,3=W).
  bit m_idle, m_stuck;
  int m_x, m_y, m_dir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clampi(input int v);
    if (v < HALF) return HALF;
    if (v > LINE_MAX - 1 - HALF) return LINE_MAX - 1 - HALF;
    return v;
  endfunction

  function automatic bit bpix(input int x, input int y, input int w, input int h);
    if (x < 0 || y < 0 || x >= w || y >= h) return 1'b0;
    return bimg[y][x];
  endfunction

  task automatic model_reset();
    m_idle = 1; m_stuck = 0; m_x = 0; m_y = 0; m_dir = 2;
  endtask

  task automatic model_load(input int x, input int y);
    m_idle = 0; m_stuck = 0; m_x = x; m_y = y; m_dir = 2;
  endtask

  // Look up the four probe pixels in the frame just sent and apply the turn rule.
  task automatic model_frame_end(input int w, input int h);
    bit open [4];
    int order [4] = '{1, 0, 3, 2};
    int d;
    bit found;
    if (m_idle || m_stuck) return;
    if (m_x + HALF >= w || m_y + HALF >= h) return;
    open[0] = bpix(m_x, m_y - HALF, w, h);
    open[1] = bpix(m_x + HALF, m_y, w, h);
    open[2] = bpix(m_x, m_y + HALF, w, h);
    open[3] = bpix(m_x - HALF, m_y, w, h);
    found = 0;
    d = 0;
    for (int k = 0; k < 4; k++) begin
      if (!found && open[(m_dir + order[k]) % 4]) begin
        found = 1;
        d = (m_dir + order[k]) % 4;
      end
    end
    if (!found) begin
      m_stuck = 1;
      return;
    end
    m_dir = d;
    case (d)
      0: m_y = clampi(m_y - STEP);
      1: m_x = clampi(m_x + STEP);
      2: m_y = clampi(m_y + STEP);
      default: m_x = clampi(m_x - STEP);
    endcase
  endtask

  task automatic issue_pixel(input int x, input int y, input int thr, input logic [1:0] md);
    logic [7:0] p, e;
    bit b;
    p = img[y][x];
    b = (p > thr);
    bimg[y][x] = b;
    if (md == 2'd0 || md == 2'd3) e = p;
    else e = b ? 8'hFF : 8'h00;
    if (md >= 2'd2 && !m_idle && abs_i(x - m_x) <= MARK_HALF && abs_i(y - m_y) <= MARK_HALF)
      e = 8'h80;
    video_data_in = p;
    threshold = thr[7:0];
    video_data_valid = 1'b1;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic send_frame(input int w, input int h, input int thr_lo, input int thr_hi,
                            input logic [1:0] md, input bit load_end, input int lx, input int ly);
    mode = md;
    video_frame_valid = 1'b1;
    tick();
    for (int y = 0; y < h; y++) begin
      video_line_valid = 1'b1;
      tick();
      for (int x = 0; x < w; x++) begin
        if ($urandom_range(0, 15) == 0) begin
          video_data_valid = 1'b0;
          tick();
        end
        issue_pixel(x, y, $urandom_range(thr_hi, thr_lo), md);
      end
      video_data_valid = 1'b0;
      tick();
      video_line_valid = 1'b0;
      tick();
    end
    video_frame_valid = 1'b0;
    if (load_end) begin
      agent_load = 1'b1;
      start_x = lx[CW-1:0];
      start_y = ly[CW-1:0];
    end
    tick();
    agent_load = 1'b0;
    if (load_end) model_load(lx, ly);
    else model_frame_end(w, h);
    repeat (4) tick();
  endtask

  task automatic load_agent(input int x, input int y);
    agent_load = 1'b1;
    start_x = x[CW-1:0];
    start_y = y[CW-1:0];
    tick();
    agent_load = 1'b0;
    model_load(x, y);
    tick();
  endtask

  task automatic check_agent(input string tag);
    check({tag, "_x"}, agent_x, m_x);
    check({tag, "_y"}, agent_y, m_y);
    check({tag, "_dir"}, agent_dir, m_dir);
    check({tag, "_stuck"}, agent_stuck, m_stuck);
  endtask

  // Closed background (0..99) with open rectangles (201..255); thresholds 100..200 keep it exact.
  task automatic fill_closed(input int w, input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) img[y][x] = 8'($urandom_range(0, 99));
  endtask

  task automatic open_rect(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) img[y][x] = 8'($urandom_range(201, 255));
  endtask

  task automatic fill_noise(input int w, input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) img[y][x] = 8'($urandom_range(0, 255));
  endtask

  always @(negedge clk) begin
    if (video_data_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pixel_unexpected: got output %0d with no pending pixel", video_data_out);
      end else begin
        check("pixel", video_data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0; mode = 2'd0; video_frame_valid = 1'b0; video_line_valid = 1'b0;
    video_data_valid = 1'b0; video_data_in = '0; threshold = '0; agent_load = 1'b0;
    start_x = '0; start_y = '0;
    model_reset();
    repeat (3) tick();
    check("rst_ready", video_data_ready, 0);
    check("rst_out", video_data_out, 0);
    check_agent("rst");
    reset = 1'b1;
    tick();

    // Threshold boundary: 150 vs 151 at threshold 150, binary mode.
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++)
        case ($urandom_range(0, 2))
          0: img[y][x] = 8'd150;
          1: img[y][x] = 8'd151;
          default: img[y][x] = 8'($urandom_range(0, 255));
        endcase
    send_frame(64, 64, 150, 150, 2'd1, 0, 0, 0);

    // Raw and raw+marker while idle (no marker may appear).
    fill_noise(32, 8);
    send_frame(32, 8, 0, 255, 2'd0, 0, 0, 0);
    send_frame(32, 8, 0, 255, 2'd3, 0, 0, 0);
    check_agent("idle");

    // Vertical corridor x=30..40: agent walks south 8 per frame.
    fill_closed(64, 64);
    open_rect(30, 40, 0, 63);
    load_agent(35, 20);
    check_agent("load");
    for (int f = 0; f < 3; f++) begin
      send_frame(64, 64, 100, 200, 2'($urandom_range(0, 3)), 0, 0, 0);
      check_agent("corr");
      check("corr_y_abs", agent_y, 28 + 8 * f);
    end

    // Corridor turns east at y=60.
    fill_closed(64, 80);
    open_rect(30, 40, 0, 65);
    open_rect(30, 63, 55, 65);
    load_agent(35, 60);
    send_frame(64, 80, 100, 200, 2'd2, 0, 0, 0);
    check_agent("turn");
    check("turn_dir_abs", agent_dir, 1);
    check("turn_x_abs", agent_x, 43);

    // Closed 9x9 box: stuck after one frame, stays put, load releases.
    fill_closed(64, 64);
    open_rect(26, 34, 26, 34);
    load_agent(30, 30);
    send_frame(64, 64, 100, 200, 2'd3, 0, 0, 0);
    check_agent("box");
    check("box_stuck_abs", agent_stuck, 1);
    send_frame(48, 48, 100, 200, 2'd2, 0, 0, 0);
    check_agent("box2");

    // Clamp at the low edge: all open, heading S turns right (W) and stops at HALF.
    fill_closed(64, 64);
    open_rect(0, 63, 0, 63);
    load_agent(18, 30);
    check("unstuck", agent_stuck, 0);
    send_frame(64, 64, 100, 200, 2'd1, 0, 0, 0);
    check_agent("clamp");
    check("clamp_x_abs", agent_x, HALF);

    // Marker square around (100,100) in binary+marker mode.
    fill_noise(110, 106);
    load_agent(100, 100);
    send_frame(110, 106, 0, 255, 2'd2, 0, 0, 0);
    check_agent("mark");

    // Load on the same cycle as frame end: load wins, no move.
    fill_closed(64, 64);
    open_rect(30, 40, 0, 63);
    load_agent(35, 20);
    send_frame(64, 64, 100, 200, 2'd0, 1, 33, 25);
    check_agent("ldend");
    check("ldend_y_abs", agent_y, 25);

    // Random mazes with random start points.
    for (int f = 0; f < 2; f++) begin
      fill_noise(48, 48);
      load_agent($urandom_range(16, 31), $urandom_range(16, 31));
      send_frame(48, 48, 100, 200, 2'($urandom_range(0, 3)), 0, 0, 0);
      check_agent("rand");
    end

    // Reset in the middle of a line.
    mode = 2'd3;
    video_frame_valid = 1'b1;
    tick();
    video_line_valid = 1'b1;
    tick();
    for (int x = 0; x < 5; x++) issue_pixel(x, 0, 128, 2'd3);
    reset = 1'b0;
    video_data_in = 8'hFF;
    video_data_valid = 1'b1;
    tick();
    model_reset();
    check("midrst_ready", video_data_ready, 0);
    check("midrst_out", video_data_out, 0);
    check_agent("midrst");
    video_data_valid = 1'b0; video_line_valid = 1'b0; video_frame_valid = 1'b0;
    reset = 1'b1;
    repeat (5) tick();
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
